// File: rtl/uart_transmitter_param.sv
// uart_transmitter_param
//   Buffered UART transmitter. Characters written by the host are queued in a
//   FIFO and serialised LSB-first on data_out as start / 5..8 data / optional
//   parity / 1..2 stop bits. Frame format and baud divisor are sampled when a
//   character leaves the FIFO, so changing them mid-frame only affects later
//   characters.
//
// Ports
//   clock                 : single clock, rising edge
//   reset                 : asynchronous, active-low
//   data_in[7:0]          : character to enqueue
//   write_enable          : enqueue data_in on this edge
//   buffer_full_threshold : fill level at which buffer_full asserts
//   baudrate_select[1:0]  : picks BAUD_DIV0..BAUD_DIV3 (cycles per bit)
//   char_length[1:0]      : 5/6/7/8 data bits
//   parity_mode[1:0]      : 00 none, 01 even, 10 odd, 11 none
//   stop_bits             : 0 one stop bit, 1 two stop bits
//   buffer_full           : fill_level >= buffer_full_threshold (combinational)
//   buffer_empty          : fill_level == 0
//   fill_level            : FIFO occupancy 0..FIFO_DEPTH
//   overflow              : one-cycle pulse after a dropped write
//   busy                  : a frame is on the line
//   data_out              : serial line, idle high
//
// Handshake: write_enable is a fire-and-forget valid; the implicit ready is
// (fill_level < FIFO_DEPTH). A write while full is dropped and reported by
// overflow in the following cycle, even if a pop happens on the same edge.
module uart_transmitter_param #(
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned BAUD_DIV0  = 5208,
  parameter int unsigned BAUD_DIV1  = 2604,
  parameter int unsigned BAUD_DIV2  = 434,
  parameter int unsigned BAUD_DIV3  = 54,
  localparam int unsigned TW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    data_in,
  input  logic          write_enable,
  input  logic [TW-1:0] buffer_full_threshold,
  input  logic [1:0]    baudrate_select,
  input  logic [1:0]    char_length,
  input  logic [1:0]    parity_mode,
  input  logic          stop_bits,
  output logic          buffer_full,
  output logic          buffer_empty,
  output logic [TW-1:0] fill_level,
  output logic          overflow,
  output logic          busy,
  output logic          data_out
);

  localparam int unsigned AW = TW - 1;
  localparam int unsigned MAX01 = (BAUD_DIV0 > BAUD_DIV1) ? BAUD_DIV0 : BAUD_DIV1;
  localparam int unsigned MAX23 = (BAUD_DIV2 > BAUD_DIV3) ? BAUD_DIV2 : BAUD_DIV3;
  localparam int unsigned DIV_MAX = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int unsigned DW = $clog2(DIV_MAX + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // FIFO storage
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [TW-1:0] count;
  logic          full;
  logic          wr_accept;
  logic          pop;
  logic [7:0]    head;

  // Transmit path
  state_t        state;
  logic [DW-1:0] div_q;
  logic [DW-1:0] bit_cnt;
  logic          bit_end;
  logic [7:0]    shift_q;
  logic [2:0]    bit_idx;
  logic [2:0]    last_idx_q;
  logic          par_en_q;
  logic          par_bit_q;
  logic          two_stop_q;
  logic          stop_idx;

  // Values captured when a character is popped
  logic [DW-1:0] sel_div;
  logic [7:0]    len_mask;
  logic          new_par_bit;

  assign full         = (count == TW'(FIFO_DEPTH));
  assign wr_accept    = write_enable && !full;
  assign head         = mem[rd_ptr];
  assign bit_end      = (bit_cnt == div_q - DW'(1));
  assign fill_level   = count;
  assign buffer_empty = (count == '0);
  assign buffer_full  = (count >= buffer_full_threshold);

  // Pop from IDLE, or on the very last cycle of the final stop bit so the
  // next start bit follows without an idle gap.
  assign pop = (count != '0) &&
               ((state == IDLE) ||
                ((state == STOP) && bit_end && (stop_idx == two_stop_q)));

  always_comb begin
    sel_div  = DW'(BAUD_DIV0);
    len_mask = 8'hFF;
    case (baudrate_select)
      2'd0:    sel_div = DW'(BAUD_DIV0);
      2'd1:    sel_div = DW'(BAUD_DIV1);
      2'd2:    sel_div = DW'(BAUD_DIV2);
      default: sel_div = DW'(BAUD_DIV3);
    endcase
    case (char_length)
      2'd0:    len_mask = 8'h1F;
      2'd1:    len_mask = 8'h3F;
      2'd2:    len_mask = 8'h7F;
      default: len_mask = 8'hFF;
    endcase
    // Even parity is the XOR of the sent bits; odd (mode 10) inverts it.
    new_par_bit = (^(head & len_mask)) ^ parity_mode[1];
  end

  always_ff @(posedge clock) begin
    if (wr_accept) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= write_enable && full;
      if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)       rd_ptr <= rd_ptr + AW'(1);
      case ({wr_accept, pop})
        2'b10:   count <= count + TW'(1);
        2'b01:   count <= count - TW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      data_out   <= 1'b1;
      busy       <= 1'b0;
      div_q      <= DW'(1);
      bit_cnt    <= '0;
      shift_q    <= '0;
      bit_idx    <= '0;
      last_idx_q <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_idx   <= 1'b0;
    end else begin
      if (state != IDLE) bit_cnt <= bit_end ? '0 : bit_cnt + DW'(1);
      case (state)
        IDLE: begin
          data_out <= 1'b1;
          busy     <= 1'b0;
          if (pop) begin
            state      <= START;
            data_out   <= 1'b0;
            busy       <= 1'b1;
            bit_cnt    <= '0;
            shift_q    <= head;
            last_idx_q <= {1'b1, char_length};
            par_en_q   <= ^parity_mode;
            par_bit_q  <= new_par_bit;
            two_stop_q <= stop_bits;
            div_q      <= sel_div;
          end
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            bit_idx  <= '0;
            data_out <= shift_q[0];
            shift_q  <= shift_q >> 1;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == last_idx_q) begin
              if (par_en_q) begin
                state    <= PARITY;
                data_out <= par_bit_q;
              end else begin
                state    <= STOP;
                stop_idx <= 1'b0;
                data_out <= 1'b1;
              end
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              data_out <= shift_q[0];
              shift_q  <= shift_q >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            stop_idx <= 1'b0;
            data_out <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_idx == two_stop_q) begin
              if (pop) begin
                state      <= START;
                data_out   <= 1'b0;
                bit_cnt    <= '0;
                shift_q    <= head;
                last_idx_q <= {1'b1, char_length};
                par_en_q   <= ^parity_mode;
                par_bit_q  <= new_par_bit;
                two_stop_q <= stop_bits;
                div_q      <= sel_div;
              end else begin
                state    <= IDLE;
                data_out <= 1'b1;
                busy     <= 1'b0;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          data_out <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter_param.sv
// tb_uart_transmitter_param
//   Bench for uart_transmitter_param with a 4-entry FIFO and short divisors.
//   Expected line activity is built from the frame rules (start, data LSB
//   first, parity, stop bits, each repeated DIV cycles) into a per-cycle queue
//   of {busy, data_out} and compared every cycle.
module tb_uart_transmitter_param;

  localparam int DEPTH = 4;
  localparam int TW    = 3;
  localparam int D0    = 4;
  localparam int D1    = 2;
  localparam int D2    = 1;
  localparam int D3    = 40;

  logic          clock;
  logic          reset;
  logic [7:0]    data_in;
  logic          write_enable;
  logic [TW-1:0] buffer_full_threshold;
  logic [1:0]    baudrate_select;
  logic [1:0]    char_length;
  logic [1:0]    parity_mode;
  logic          stop_bits;
  logic          buffer_full;
  logic          buffer_empty;
  logic [TW-1:0] fill_level;
  logic          overflow;
  logic          busy;
  logic          data_out;

  uart_transmitter_param #(
    .FIFO_DEPTH(DEPTH), .BAUD_DIV0(D0), .BAUD_DIV1(D1),
    .BAUD_DIV2(D2), .BAUD_DIV3(D3)
  ) dut (
    .clock(clock), .reset(reset), .data_in(data_in),
    .write_enable(write_enable),
    .buffer_full_threshold(buffer_full_threshold),
    .baudrate_select(baudrate_select), .char_length(char_length),
    .parity_mode(parity_mode), .stop_bits(stop_bits),
    .buffer_full(buffer_full), .buffer_empty(buffer_empty),
    .fill_level(fill_level), .overflow(overflow), .busy(busy),
    .data_out(data_out)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int div_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return D0;
      2'd1:    return D1;
      2'd2:    return D2;
      default: return D3;
    endcase
  endfunction

  // Reference frame: list of line bits, each held for div cycles with busy=1.
  task automatic push_frame(input logic [7:0] c, input int len, input logic [1:0] par,
                            input int stops, input int div);
    logic bits[$];
    logic p;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      bits.push_back(c[i]);
      p = p ^ c[i];
    end
    if (par == 2'b01) bits.push_back(p);
    else if (par == 2'b10) bits.push_back(~p);
    for (int i = 0; i < stops; i++) bits.push_back(1'b1);
    foreach (bits[i]) repeat (div) exp_q.push_back({1'b1, bits[i]});
  endtask

  // ---------------- driver ----------------
  // Writes k characters on consecutive edges and checks the line every cycle.
  // If chg_cyc >= 0, char_length is switched to 8 bits at that cycle.
  task automatic run_stream(input int k, input logic [7:0] ch[4], input int chg_cyc);
    int total;
    logic [1:0] e;
    exp_q.delete();
    exp_q.push_back(2'b01);
    for (int i = 0; i < k; i++)
      push_frame(ch[i], int'(char_length) + 5, parity_mode, int'(stop_bits) + 1,
                 div_of(baudrate_select));
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    total = exp_q.size();
    for (int cyc = 0; cyc <= total; cyc++) begin
      @(negedge clock);
      if (cyc >= 1) begin
        e = exp_q.pop_front();
        check($sformatf("line@%0d", cyc), {30'd0, busy, data_out}, {30'd0, e});
      end
      if (cyc < k) begin
        write_enable = 1'b1;
        data_in      = ch[cyc];
      end else begin
        write_enable = 1'b0;
      end
      if (cyc == chg_cyc) char_length = 2'b11;
    end
    check("stream_empty", {31'd0, buffer_empty}, 32'd1);
    check("stream_fill", {29'd0, fill_level}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] ch[4];
    int occ;
    logic drop;

    reset = 1'b0;
    data_in = 8'h00;
    write_enable = 1'b0;
    buffer_full_threshold = '0;
    baudrate_select = 2'd0;
    char_length = 2'b11;
    parity_mode = 2'b00;
    stop_bits = 1'b0;

    // Reset values
    repeat (5) @(negedge clock);
    check("rst_data_out", {31'd0, data_out}, 32'd1);
    check("rst_empty", {31'd0, buffer_empty}, 32'd1);
    check("rst_fill", {29'd0, fill_level}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_full_thr0", {31'd0, buffer_full}, 32'd1);
    buffer_full_threshold = 3'd4;
    #1;
    check("rst_full_thr4", {31'd0, buffer_full}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // 8N1, 0xA5
    ch = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_stream(1, ch, -1);

    // 7E2 back-to-back, bit 7 ignored
    char_length = 2'b10; parity_mode = 2'b01; stop_bits = 1'b1;
    ch = '{8'h7F, 8'h01, 8'h00, 8'h00};
    run_stream(2, ch, -1);

    // 5O1 with char_length changed during the data bits
    char_length = 2'b00; parity_mode = 2'b10; stop_bits = 1'b0;
    ch = '{8'h1F, 8'h00, 8'h00, 8'h00};
    run_stream(1, ch, 10);

    // Randomized batches
    for (int b = 0; b < 10; b++) begin
      char_length     = 2'($urandom_range(0, 3));
      parity_mode     = 2'($urandom_range(0, 3));
      stop_bits       = 1'($urandom_range(0, 1));
      baudrate_select = 2'($urandom_range(0, 2));
      for (int i = 0; i < 4; i++) ch[i] = 8'($urandom);
      run_stream($urandom_range(1, 4), ch, -1);
    end

    // Overflow / threshold: six writes on consecutive edges, slow divisor.
    // Only the first character leaves the FIFO (edge 1) during this window.
    baudrate_select = 2'd3; char_length = 2'b11; parity_mode = 2'b00; stop_bits = 1'b0;
    buffer_full_threshold = 3'd3;
    occ = 0;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clock);
      if (i >= 1) begin
        drop = 1'b0;
        if (i - 1 < 6) begin
          if (occ == DEPTH) drop = 1'b1;
          else occ++;
        end
        if (i - 1 == 1) occ--;
        check($sformatf("ovf_fill@%0d", i), {29'd0, fill_level}, 32'(occ));
        check($sformatf("ovf_pulse@%0d", i), {31'd0, overflow}, {31'd0, drop});
        check($sformatf("ovf_full@%0d", i), {31'd0, buffer_full}, {31'd0, (occ >= 3)});
      end
      write_enable = (i < 6);
      data_in = 8'h00;
    end
    buffer_full_threshold = 3'd7;
    #1 check("thr_above_depth", {31'd0, buffer_full}, 32'd0);
    buffer_full_threshold = 3'd4;
    #1 check("thr_eq_depth", {31'd0, buffer_full}, 32'd1);
    buffer_full_threshold = 3'd0;
    #1 check("thr_zero", {31'd0, buffer_full}, 32'd1);

    // Reset mid-frame: data bits of 0x00 hold the line low before reset.
    repeat (40) @(negedge clock);
    check("pre_rst_line", {30'd0, busy, data_out}, 32'd2);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_line", {31'd0, data_out}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_fill", {29'd0, fill_level}, 32'd0);
    check("mid_rst_empty", {31'd0, buffer_empty}, 32'd1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      check($sformatf("post_rst@%0d", i), {30'd0, busy, data_out}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
